// File: rtl/m_lsu.sv
// Memory-stage load/store unit: sequential bus master with misalignment detection,
// store lane replication/byte enables and load lane extraction with sign/zero extension.
module m_lsu #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [AW-1:0]     req_addr,
    input  logic [DW-1:0]     req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW/8-1:0]   mem_be,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DW-1:0]     mem_rdata,
    output logic              rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic [1:0]        rsp_exc,
    output logic              stall
);
    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          state_r;
    logic            we_r;
    logic [1:0]      size_r;
    logic            signed_r;
    logic [OW-1:0]   off_r;
    logic            misaligned_s;
    logic [DW-1:0]   load_data_s;

    // Shift the addressed lane down, mask to the access width and fill the upper bits.
    function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] rdata,
                                                  input logic [OW-1:0] off,
                                                  input logic [1:0]    size,
                                                  input logic          sgn);
        logic [DW-1:0] sh_v;
        logic [DW-1:0] mask_v;
        logic [6:0]    w_v;
        logic          msb_v;
        sh_v = rdata >> {off, 3'b000};
        w_v  = 7'd8 << size;
        if (w_v > 7'(DW)) begin
            w_v = 7'(DW);
        end else begin
            w_v = w_v;
        end
        mask_v = ~({DW{1'b1}} << w_v);
        // Top bit of the mask marks the sign position of the extracted lane.
        msb_v  = |(sh_v & (mask_v ^ (mask_v >> 1)));
        return (sh_v & mask_v) | ((sgn && msb_v) ? ~mask_v : {DW{1'b0}});
    endfunction

    function automatic logic [NB-1:0] store_be(input logic [OW-1:0] off,
                                               input logic [1:0]    size);
        logic [NB-1:0] base_v;
        case (size)
            2'd0:    base_v = NB'(4'h1);
            2'd1:    base_v = NB'(4'h3);
            2'd2:    base_v = NB'(4'hF);
            default: base_v = {NB{1'b1}};
        endcase
        return base_v << off;
    endfunction

    function automatic logic [DW-1:0] store_data(input logic [DW-1:0] wdata,
                                                 input logic [1:0]    size);
        logic [DW-1:0] r_v;
        r_v = wdata;
        for (int i = 0; i < NB; i++) begin
            case (size)
                2'd0:    r_v[8*i +: 8] = wdata[7:0];
                2'd1:    r_v[8*i +: 8] = wdata[8*(i%2) +: 8];
                2'd2:    r_v[8*i +: 8] = wdata[8*(i%4) +: 8];
                default: r_v[8*i +: 8] = wdata[8*i +: 8];
            endcase
        end
        return r_v;
    endfunction

    // Alignment check on the incoming request; dword only exists on a 64-bit bus.
    always_comb begin
        misaligned_s = 1'b0;
        case (req_size)
            2'd0:    misaligned_s = 1'b0;
            2'd1:    misaligned_s = req_addr[0];
            2'd2:    misaligned_s = |req_addr[1:0];
            2'd3:    misaligned_s = (DW != 64) || (|req_addr[2:0]);
            default: misaligned_s = 1'b1;
        endcase
    end

    assign load_data_s = load_extend(mem_rdata, off_r, size_r, signed_r);
    assign req_ready   = (state_r == S_IDLE);
    assign stall       = req_valid & ~req_ready;

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            we_r      <= 1'b0;
            size_r    <= 2'd0;
            signed_r  <= 1'b0;
            off_r     <= {OW{1'b0}};
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_be    <= {NB{1'b0}};
            mem_wdata <= {DW{1'b0}};
            rsp_valid <= 1'b0;
            rsp_rdata <= {DW{1'b0}};
            rsp_exc   <= 2'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        we_r     <= req_we;
                        size_r   <= req_size;
                        signed_r <= req_signed;
                        off_r    <= req_addr[OW-1:0];
                        if (misaligned_s) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= {DW{1'b0}};
                            rsp_exc   <= req_we ? 2'd2 : 2'd1;
                            state_r   <= S_RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[AW-1:OW], {OW{1'b0}}};
                            mem_be    <= req_we ? store_be(req_addr[OW-1:0], req_size)
                                                : {NB{1'b1}};
                            mem_wdata <= store_data(req_wdata, req_size);
                            state_r   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (we_r) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= {DW{1'b0}};
                            rsp_exc   <= 2'd0;
                            state_r   <= S_RESP;
                        end else if (mem_rvalid) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= load_data_s;
                            rsp_exc   <= 2'd0;
                            state_r   <= S_RESP;
                        end else begin
                            state_r   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= load_data_s;
                        rsp_exc   <= 2'd0;
                        state_r   <= S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_exc   <= 2'd0;
                    state_r   <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/m_lsu.md
# m_lsu

Memory-stage load/store unit that replaces the purely combinational load-extension path with a sequential bus master. It accepts one load or store per transaction from the M stage and drives a data-memory port that may insert wait states. For loads it extracts and sign/zero-extends the addressed lane; for stores it generates byte enables and replicates lanes. Misaligned accesses raise an address-error code, and the unit stalls the pipeline while a transaction is open. Data width is parametrised (32 or 64 bits).

## Interface
- DW, 32, data width; legal values 32 and 64
- AW, 32, byte-address width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  1  M stage presents an access
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (dword legal only when DW=64)
- req_signed  in  1  loads: 1 sign-extend, 0 zero-extend; ignored for stores
- req_addr  in  AW  byte address
- req_wdata  in  DW  store data, right-justified
- mem_req  out  1  bus request, held until granted
- mem_we  out  1  bus write
- mem_addr  out  AW  req_addr with low log2(DW/8) bits cleared
- mem_be  out  DW/8  byte enables (all ones for loads)
- mem_wdata  out  DW  lane-replicated store data
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DW  read data, full aligned word
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DW  extended load result; 0 for stores and exceptions
- rsp_exc  out  2  0 none, 1 AdEL (load), 2 AdES (store)
- stall  out  1  req_valid & ~req_ready

## Operation
- States: IDLE, REQ, WAIT, RESP. All outputs are registered from state or captured fields, except stall.
- IDLE: req_ready=1. On req_valid, capture we/size/signed/addr/wdata. Misalignment check: size 1 needs addr[0]=0; size 2 needs addr[1:0]=0; size 3 needs addr[2:0]=0. Size 3 with DW=32 is always illegal. Illegal -> RESP with rsp_exc set and no bus activity. Legal -> REQ.
- REQ: mem_req=1; mem_addr, mem_we, mem_be, mem_wdata held stable. On mem_gnt: a store goes to RESP; a load goes to WAIT. If mem_rvalid is also high in the same cycle, the load captures data and goes to RESP.
- WAIT: mem_req=0. On mem_rvalid, capture the extracted result and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Lane select uses offset o = addr[log2(DW/8)-1:0].
  - byte: lane o
  - half: lanes o, o+1
  - word: lanes o..o+3
  - dword: all lanes
- Store mem_be is ones over the selected lanes. mem_wdata replicates the low 8/16/32 bits of req_wdata across every lane of that size.
- Load extension:
  - Take bits [8<<size)-1 : 0] of mem_rdata >> (8·o).
  - Upper bits are filled with the MSB if req_signed, else zeros.
  - Dword ignores req_signed.
  - req_signed is ignored for word when DW=32.
- mem_rvalid outside WAIT is ignored, except the same-cycle case in REQ. mem_gnt outside REQ is ignored.

## Timing
- Reset values: state IDLE; req_ready=1; mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0; rsp_valid=0, rsp_rdata=0, rsp_exc=0.
- Acceptance at cycle 0 puts mem_req high at cycle 1.
- Store with immediate gnt: rsp_valid at cycle 2.
- Load with gnt at 1 and rvalid at 2: rsp_valid at cycle 3. With gnt+rvalid both at 1: rsp_valid at cycle 2.
- Exception: rsp_valid at cycle 1, mem_req never asserted.
- Each gnt/rvalid wait state adds one cycle. There is no timeout.
- Reset asserted mid-transaction returns to IDLE immediately, drops mem_req, and suppresses the pending rsp_valid. A late rvalid after reset is ignored.
- Back-to-back accesses: the next request can be accepted in the cycle after RESP, giving a minimum of 3 cycles per store.

## Test plan
- DW=32, load byte signed at addr 0x...03, rdata 0x80FF_1234 -> rsp_rdata 0xFFFF_FF80. Same access unsigned -> 0x0000_0080.
- DW=32, store half at addr 0x...02, wdata 0x0000_BEEF -> mem_be 4'b1100, mem_wdata 0xBEEF_BEEF, mem_addr low bits 00, rsp_valid 2 cycles after accept.
- Load word at addr 0x...06 -> rsp_exc=1 at cycle 1, mem_req stays 0. Store word at 0x...01 -> rsp_exc=2.
- Load with mem_gnt delayed 3 cycles and mem_rvalid 2 cycles after gnt -> mem_req held 4 cycles with stable address, stall high throughout, single rsp_valid pulse.
- DW=64, load half unsigned at addr 0x...06, rdata 0xABCD_0000_0000_0000 -> mem_be 8'hFF, rsp_rdata 0x0000_0000_0000_ABCD. Dword at 0x...04 -> AdEL.
- Assert reset while in WAIT, then pulse mem_rvalid -> no rsp_valid, all outputs at reset values, next request proceeds normally.
